// File: rtl/cpu_pkg.sv
// Shared branch-resolution definitions: branch opcode and recovery FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

    // Conditional branch opcode (B-type) as seen in the EX stage.
    localparam logic [6:0] BR_OP = 7'b110_0011;

    // Saturation ceiling for the optional statistics counters.
    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    // IDLE: redirects allowed. RECOVER: one-cycle shadow after a redirect in
    // which the wrong-path instruction sitting in EX must not redirect again.
    typedef enum logic {
        IDLE    = 1'b0,
        RECOVER = 1'b1
    } br_state_e;

endpackage

// File: rtl/pred_pipe_reg.sv
// One pipeline stage of the branch prediction {taken, target} bundle.
// Latency: 1 cycle (registered capture on the rising edge).
// Backpressure: stall holds the current contents; flush clears and beats stall.
module pred_pipe_reg #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall,
    input  logic         flush,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    // Next value: flush clears, otherwise capture unless stalled.
    always_comb begin
        q_d = q_q;
        if (flush) begin
            q_d = '0;
        end else if (!stall) begin
            q_d = d;
        end
    end

    // Stage register with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/branch_resolve.sv
// Carries the IF-stage prediction to EX and resolves it; redirects fetch on a mispredict. Optional BR_STATS_EN adds counters.
// Latency: prediction reaches EX after 2 edges; RedirectE/RedirectPC are combinational in EX (zero cycles).
// Backpressure: StallD/StallE hold the stages and the FSM, keeping RedirectE asserted as a level; flushes clear stages.
module branch_resolve
    import cpu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            PredictedF,
    input  logic [XLEN-1:0] PredictedPC,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            StallE,
    input  logic            FlushE,
    input  logic [XLEN-1:0] PCE,
    input  logic [6:0]      OpE,
    input  logic            BranchE,
    input  logic [XLEN-1:0] BrNPC,
    output logic            RedirectE,
    output logic [XLEN-1:0] RedirectPC,
    output logic            PredTakenE
`ifdef BR_STATS_EN
    ,
    output logic [31:0]     BranchCnt,
    output logic [31:0]     MispredCnt
`endif
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    logic [XLEN:0]   pred_f;
    logic [XLEN:0]   pred_d;
    logic [XLEN:0]   pred_e;
    logic            pred_taken_e;
    logic [XLEN-1:0] pred_pc_e;
    logic            is_br;
    logic            mispred;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    br_state_e       state_q;
    br_state_e       state_d;

    assign pred_f = {PredictedF, PredictedPC};

    pred_pipe_reg #(.W(XLEN + 1)) u_pred_fd (
        .clk   (clk),
        .rst   (rst),
        .stall (StallD),
        .flush (FlushD),
        .d     (pred_f),
        .q     (pred_d)
    );

    pred_pipe_reg #(.W(XLEN + 1)) u_pred_de (
        .clk   (clk),
        .rst   (rst),
        .stall (StallE),
        .flush (FlushE),
        .d     (pred_d),
        .q     (pred_e)
    );

    assign pred_taken_e = pred_e[XLEN];
    assign pred_pc_e    = pred_e[XLEN-1:0];
    assign is_br        = (OpE == BR_OP);

    // Mispredict: wrong direction, wrong target on a taken hit, or a BTB hit
    // on an instruction that is not a branch at all (stale alias).
    always_comb begin
        mispred = 1'b0;
        if (is_br) begin
            mispred = (BranchE != pred_taken_e) ||
                      (BranchE && pred_taken_e && (BrNPC != pred_pc_e));
        end else begin
            mispred = pred_taken_e;
        end
    end

    // Redirect gating and recovery FSM next state.
    always_comb begin
        state_d  = state_q;
        redirect = 1'b0;
        if (!rst && (state_q == IDLE)) begin
            redirect = mispred;
        end
        case (state_q)
            IDLE: begin
                if (redirect && !StallE) begin
                    state_d = RECOVER;
                end
            end
            RECOVER: begin
                if (!StallE) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Recovery FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Corrected fetch address: real target if taken, else fall-through (wraps).
    always_comb begin
        redirect_pc = '0;
        if (!rst) begin
            if (is_br && BranchE) begin
                redirect_pc = BrNPC;
            end else begin
                redirect_pc = PCE + PC_STEP;
            end
        end
    end

    assign RedirectE  = redirect;
    assign RedirectPC = redirect_pc;
    assign PredTakenE = rst ? 1'b0 : pred_taken_e;

`ifdef BR_STATS_EN
    logic [31:0] branch_cnt_q;
    logic [31:0] branch_cnt_d;
    logic [31:0] mispred_cnt_q;
    logic [31:0] mispred_cnt_d;

    // Saturating statistics; stalled cycles are not counted so a held
    // instruction is counted once, when it finally leaves EX.
    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (is_br && (state_q == IDLE) && !StallE && (branch_cnt_q != CNT_MAX)) begin
            branch_cnt_d = branch_cnt_q + 32'd1;
        end
        if (redirect && !StallE && (mispred_cnt_q != CNT_MAX)) begin
            mispred_cnt_d = mispred_cnt_q + 32'd1;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign BranchCnt  = branch_cnt_q;
    assign MispredCnt = mispred_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve with a queue-based scoreboard.
// Stimulus pushes one expected record per cycle; a negedge monitor pops and checks.
// Counter checks are active only when BR_STATS_EN is defined.
module tb_branch_resolve;
    import cpu_pkg::*;

    localparam logic [6:0] NOP = 7'h13;

    logic        clk = 1'b0;
    logic        rst;
    logic        PredictedF;
    logic [31:0] PredictedPC;
    logic        StallD, FlushD, StallE, FlushE;
    logic [31:0] PCE;
    logic [6:0]  OpE;
    logic        BranchE;
    logic [31:0] BrNPC;
    logic        RedirectE;
    logic [31:0] RedirectPC;
    logic        PredTakenE;
`ifdef BR_STATS_EN
    logic [31:0] BranchCnt;
    logic [31:0] MispredCnt;
`endif

    always #5 clk = ~clk;

    branch_resolve #(.XLEN(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .PredictedF  (PredictedF),
        .PredictedPC (PredictedPC),
        .StallD      (StallD),
        .FlushD      (FlushD),
        .StallE      (StallE),
        .FlushE      (FlushE),
        .PCE         (PCE),
        .OpE         (OpE),
        .BranchE     (BranchE),
        .BrNPC       (BrNPC),
        .RedirectE   (RedirectE),
        .RedirectPC  (RedirectPC),
        .PredTakenE  (PredTakenE)
`ifdef BR_STATS_EN
        ,
        .BranchCnt   (BranchCnt),
        .MispredCnt  (MispredCnt)
`endif
    );

    typedef struct {
        logic        chk_pc;
        logic        redir;
        logic [31:0] rpc;
        logic        ptk;
        logic [31:0] bcnt;
        logic [31:0] mcnt;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    exp_t  mon_e;
    string mon_nm;
    int    vec_cnt = 0;
    int    err_cnt = 0;

    // Monitor: compare DUT outputs against the oldest expectation, mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e  = exp_q.pop_front();
            mon_nm = name_q.pop_front();
            vec_cnt++;
            if (RedirectE !== mon_e.redir) begin
                err_cnt++;
                $display("FAIL %s RedirectE got %0b want %0b", mon_nm, RedirectE, mon_e.redir);
            end
            if (PredTakenE !== mon_e.ptk) begin
                err_cnt++;
                $display("FAIL %s PredTakenE got %0b want %0b", mon_nm, PredTakenE, mon_e.ptk);
            end
            if (mon_e.chk_pc && (RedirectPC !== mon_e.rpc)) begin
                err_cnt++;
                $display("FAIL %s RedirectPC got %h want %h", mon_nm, RedirectPC, mon_e.rpc);
            end
`ifdef BR_STATS_EN
            if (BranchCnt !== mon_e.bcnt) begin
                err_cnt++;
                $display("FAIL %s BranchCnt got %0d want %0d", mon_nm, BranchCnt, mon_e.bcnt);
            end
            if (MispredCnt !== mon_e.mcnt) begin
                err_cnt++;
                $display("FAIL %s MispredCnt got %0d want %0d", mon_nm, MispredCnt, mon_e.mcnt);
            end
`endif
        end
    end

    task automatic fe_in(input logic pf, input logic [31:0] ppc);
        PredictedF  = pf;
        PredictedPC = ppc;
    endtask

    task automatic ex_in(input logic [6:0] op, input logic [31:0] pce,
                         input logic br, input logic [31:0] npc);
        OpE     = op;
        PCE     = pce;
        BranchE = br;
        BrNPC   = npc;
    endtask

    task automatic hz(input logic sd, input logic fd, input logic se, input logic fe);
        StallD = sd;
        FlushD = fd;
        StallE = se;
        FlushE = fe;
    endtask

    // Queue the expectation for the current cycle, then advance one clock.
    task automatic cyc(input string nm, input logic cpc, input logic redir,
                       input logic [31:0] rpc, input logic ptk,
                       input logic [31:0] bc, input logic [31:0] mc);
        exp_t e;
        e.chk_pc = cpc;
        e.redir  = redir;
        e.rpc    = rpc;
        e.ptk    = ptk;
        e.bcnt   = bc;
        e.mcnt   = mc;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    // Directed sequence; expected values are hand-derived per cycle.
    initial begin
        rst = 1'b1;
        fe_in(1'b1, 32'h100);
        ex_in(BR_OP, 32'h40, 1'b1, 32'h80);
        hz(1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        // Reset forces outputs low even with a mispredicting branch in EX.
        cyc("rst_out",          1'b1, 1'b0, 32'h0,   1'b0, 0, 0);
        rst = 1'b0;
        fe_in(1'b1, 32'h100);
        ex_in(NOP, 32'h0, 1'b0, 32'h0);
        cyc("idle",             1'b0, 1'b0, 32'h0,   1'b0, 0, 0);
        fe_in(1'b0, 32'h0);
        cyc("pipe_fill",        1'b0, 1'b0, 32'h0,   1'b0, 0, 0);
        // Correct taken prediction to 0x100.
        ex_in(BR_OP, 32'h40, 1'b1, 32'h100);
        cyc("pred_hit",         1'b0, 1'b0, 32'h0,   1'b1, 0, 0);
        ex_in(NOP, 32'h0, 1'b0, 32'h0);
        cyc("hit_cnt",          1'b0, 1'b0, 32'h0,   1'b0, 1, 0);
        // No prediction, branch taken to 0x80; the next cycle is RECOVER.
        ex_in(BR_OP, 32'h40, 1'b1, 32'h80);
        cyc("miss_taken",       1'b1, 1'b1, 32'h80,  1'b0, 1, 0);
        cyc("recover_mask",     1'b0, 1'b0, 32'h0,   1'b0, 2, 1);
        ex_in(NOP, 32'h0, 1'b0, 32'h0);
        fe_in(1'b1, 32'h100);
        cyc("recover_exit",     1'b0, 1'b0, 32'h0,   1'b0, 2, 1);
        fe_in(1'b0, 32'h0);
        cyc("fill2",            1'b0, 1'b0, 32'h0,   1'b0, 2, 1);
        // Predicted taken, actually not taken: fall-through 0x44.
        ex_in(BR_OP, 32'h40, 1'b0, 32'h100);
        cyc("miss_nt",          1'b1, 1'b1, 32'h44,  1'b1, 2, 1);
        ex_in(NOP, 32'h0, 1'b0, 32'h0);
        fe_in(1'b1, 32'h100);
        cyc("after_nt",         1'b0, 1'b0, 32'h0,   1'b0, 3, 2);
        fe_in(1'b0, 32'h0);
        cyc("fill3",            1'b0, 1'b0, 32'h0,   1'b0, 3, 2);
        // Wrong target 0x200, held by StallE for two cycles.
        ex_in(BR_OP, 32'h40, 1'b1, 32'h200);
        hz(1'b0, 1'b0, 1'b1, 1'b0);
        cyc("tgt_stall1",       1'b1, 1'b1, 32'h200, 1'b1, 3, 2);
        cyc("tgt_stall2",       1'b1, 1'b1, 32'h200, 1'b1, 3, 2);
        hz(1'b0, 1'b0, 1'b0, 1'b0);
        cyc("tgt_release",      1'b1, 1'b1, 32'h200, 1'b1, 3, 2);
        // Prediction killed by FlushD never reaches EX.
        ex_in(NOP, 32'h0, 1'b0, 32'h0);
        fe_in(1'b1, 32'h300);
        hz(1'b0, 1'b1, 1'b0, 1'b0);
        cyc("flushd_a",         1'b0, 1'b0, 32'h0,   1'b0, 4, 3);
        fe_in(1'b0, 32'h0);
        hz(1'b0, 1'b0, 1'b0, 1'b0);
        cyc("flushd_b",         1'b0, 1'b0, 32'h0,   1'b0, 4, 3);
        fe_in(1'b1, 32'h500);
        cyc("flushd_c",         1'b0, 1'b0, 32'h0,   1'b0, 4, 3);
        fe_in(1'b0, 32'h0);
        cyc("fill4",            1'b0, 1'b0, 32'h0,   1'b0, 4, 3);
        // Stale hit on a non-branch at the top of memory, with FlushE.
        ex_in(NOP, 32'hFFFF_FFFC, 1'b0, 32'h0);
        hz(1'b0, 1'b0, 1'b0, 1'b1);
        cyc("stale_wrap",       1'b1, 1'b1, 32'h0,   1'b1, 4, 3);
        ex_in(NOP, 32'h0, 1'b0, 32'h0);
        hz(1'b0, 1'b0, 1'b0, 1'b0);
        fe_in(1'b1, 32'h600);
        cyc("flushe_clr",       1'b0, 1'b0, 32'h0,   1'b0, 4, 4);
        fe_in(1'b0, 32'h0);
        cyc("fill5",            1'b0, 1'b0, 32'h0,   1'b0, 4, 4);
        // Stale hit while StallE and FlushE are both high: flush wins.
        ex_in(NOP, 32'h80, 1'b0, 32'h0);
        hz(1'b0, 1'b0, 1'b1, 1'b1);
        cyc("stall_flush",      1'b1, 1'b1, 32'h84,  1'b1, 4, 4);
        hz(1'b0, 1'b0, 1'b0, 1'b0);
        cyc("flush_over_stall", 1'b0, 1'b0, 32'h0,   1'b0, 4, 4);
        // Enter RECOVER, then reset in the middle of it.
        ex_in(BR_OP, 32'h40, 1'b1, 32'h80);
        cyc("miss_pre_rst",     1'b1, 1'b1, 32'h80,  1'b0, 4, 4);
        rst = 1'b1;
        cyc("rst_in_recover",   1'b1, 1'b0, 32'h0,   1'b0, 5, 5);
        rst = 1'b0;
        ex_in(NOP, 32'h0, 1'b0, 32'h0);
        cyc("post_rst",         1'b0, 1'b0, 32'h0,   1'b0, 0, 0);
        // Back in IDLE: a fresh mispredict redirects immediately.
        ex_in(BR_OP, 32'h40, 1'b1, 32'h80);
        cyc("idle_after_rst",   1'b1, 1'b1, 32'h80,  1'b0, 0, 0);
        ex_in(NOP, 32'h0, 1'b0, 32'h0);
        cyc("final",            1'b0, 1'b0, 32'h0,   1'b0, 1, 1);

        for (int i = 0; i < 5 && exp_q.size() != 0; i++) begin
            @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            $display("FAIL drain scoreboard left %0d want 0", exp_q.size());
            $fatal(1, "scoreboard did not drain");
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
